// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch unit: classic Wishbone reads run ahead of decode into a DEPTH-entry FIFO.
// Define IF_PREFETCH_BYPASS_EN to present an ack straight to the consumer while the FIFO is empty.
module if_prefetch_buffer #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_addr_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_instr_o,
    output logic [31:0]            out_pc_o,
    output logic                   out_err_o,
    output logic [$clog2(DEPTH):0] level_o,
    input  logic [31:0]            wbm_dat_i,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic [31:0]            wbm_addr_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HALT
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    entry_t      head;
    entry_t      push_entry;
    logic [AW:0] level;
    logic [AW:0] level_after;
    logic        cyc_open;
    logic        term;
    logic        resp_ok;
    logic        bypass_hit;
    logic        bypass_take;
    logic        fifo_pop;
    logic        push;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign cyc_open = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign term     = cyc_open && (wbm_ack_i || wbm_err_i);

    // Only a response to a live FETCH with no competing flush carries an instruction.
    assign resp_ok  = (state_q == S_FETCH) && term && !redirect_i;

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass_hit = resp_ok && wbm_ack_i && !wbm_err_i && (level == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign bypass_take = bypass_hit && out_ready_i;
    assign fifo_pop    = (level != '0) && out_ready_i && !redirect_i;
    assign push        = resp_ok && !bypass_take;

    assign push_entry = '{pc:    fpc_q,
                          instr: wbm_err_i ? NOP : wbm_dat_i,
                          err:   wbm_err_i};

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        drain_addr_d = drain_addr_q;
        rd_ptr_d     = rd_ptr_q + (AW + 1)'(fifo_pop);
        wr_ptr_d     = wr_ptr_q + (AW + 1)'(push);
        level_after  = wr_ptr_d - rd_ptr_d;

        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fpc_d    = redirect_addr_i & 32'hFFFF_FFFC;
            if (cyc_open && !term) begin
                state_d = S_DRAIN;
                // The open cycle keeps its original address until the slave terminates it.
                if (state_q == S_FETCH) begin
                    drain_addr_d = fpc_q;
                end
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (level_after < DEPTH_L) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (wbm_err_i) begin
                        state_d = S_HALT;
                    end else if (wbm_ack_i) begin
                        fpc_d = fpc_q + 32'd4;
                        if (level_after >= DEPTH_L) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (term) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry;
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            fpc_q        <= RESET_ADDR;
            drain_addr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            drain_addr_q <= drain_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // NOTE: the entry array is reset on purpose: a freshly reset buffer must hold only zeroed entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        out_valid_o = 1'b0;
        out_instr_o = '0;
        out_pc_o    = '0;
        out_err_o   = 1'b0;
        if (level != '0) begin
            out_valid_o = 1'b1;
            out_instr_o = head.instr;
            out_pc_o    = head.pc;
            out_err_o   = head.err;
        end else if (bypass_hit) begin
            out_valid_o = 1'b1;
            out_instr_o = wbm_dat_i;
            out_pc_o    = fpc_q;
        end
    end

    assign level_o    = level;
    assign wbm_cyc_o  = cyc_open;
    assign wbm_stb_o  = cyc_open;
    assign wbm_addr_o = (state_q == S_DRAIN) ? drain_addr_q : fpc_q;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer: Wishbone slave model, scoreboard queue and
// directed scenarios followed by randomized traffic.
module tb_if_prefetch_buffer;

    localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
    localparam int          DEPTH      = 4;
    localparam int          LW         = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_addr_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [31:0]   out_instr_o;
    logic [31:0]   out_pc_o;
    logic          out_err_o;
    logic [LW-1:0] level_o;
    logic [31:0]   wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0;
    logic          wbm_err_i = 1'b0;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic [31:0]   wbm_addr_o;

    if_prefetch_buffer #(
        .RESET_ADDR(RESET_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_instr_o    (out_instr_o),
        .out_pc_o       (out_pc_o),
        .out_err_o      (out_err_o),
        .level_o        (level_o),
        .wbm_dat_i      (wbm_dat_i),
        .wbm_ack_i      (wbm_ack_i),
        .wbm_err_i      (wbm_err_i),
        .wbm_cyc_o      (wbm_cyc_o),
        .wbm_stb_o      (wbm_stb_o),
        .wbm_addr_o     (wbm_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_acks = 0;

    // Reference model state: expected FIFO contents and expected next fetch address.
    exp_t        q[$];
    logic [31:0] exp_fa = RESET_ADDR;
    logic        halted = 1'b0;
    logic        stale = 1'b0;

    // Slave model state.
    logic        slv_busy = 1'b0;
    logic [31:0] slv_addr = '0;
    int          slv_wait = 0;
    int          fixed_wait = 0;
    int          max_wait = 3;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        rand_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic err_hit(input logic [31:0] a);
        return (err_en && (a == err_addr)) || (rand_err && (a[6:2] == 5'd19));
    endfunction

    // One clock: drive inputs after the edge, answer the bus, then check and advance the model.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] ra);
        logic new_cyc;
        logic term;
        logic byp;
        exp_t e;
        @(posedge clk_i);
        #1;
        out_ready_i     = rdy;
        redirect_i      = rd;
        redirect_addr_i = ra;
        wbm_ack_i       = 1'b0;
        wbm_err_i       = 1'b0;
        wbm_dat_i       = '0;
        new_cyc         = 1'b0;
        if (slv_busy) begin
            check("cyc_hold", 64'(wbm_cyc_o), 64'd1);
            check("addr_hold", 64'(wbm_addr_o), 64'(slv_addr));
        end
        if (wbm_cyc_o) begin
            if (!slv_busy) begin
                slv_busy = 1'b1;
                new_cyc  = 1'b1;
                slv_addr = wbm_addr_o;
                slv_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
            end
            if (slv_wait == 0) begin
                slv_busy = 1'b0;
                if (err_hit(slv_addr)) begin
                    wbm_err_i = 1'b1;
                end else begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = instr_fn(slv_addr);
                    n_acks++;
                end
            end else begin
                slv_wait--;
            end
        end
        term = wbm_ack_i | wbm_err_i;

        @(negedge clk_i);
        check("stb_eq_cyc", 64'(wbm_stb_o), 64'(wbm_cyc_o));
        if (halted) check("halt_no_cyc", 64'(wbm_cyc_o), 64'd0);
        if (new_cyc && !stale) check("fetch_addr", 64'(wbm_addr_o), 64'(exp_fa));
        byp = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
        byp = (q.size() == 0) && wbm_ack_i && !stale && !rd;
`endif
        check("level", 64'(level_o), 64'(q.size()));
        check("out_valid", 64'(out_valid_o), 64'((q.size() != 0) || byp));
        if (q.size() != 0) begin
            check("head_pc", 64'(out_pc_o), 64'(q[0].pc));
            check("head_instr", 64'(out_instr_o), 64'(q[0].instr));
            check("head_err", 64'(out_err_o), 64'(q[0].err));
        end else if (byp) begin
            check("bypass_pc", 64'(out_pc_o), 64'(slv_addr));
            check("bypass_instr", 64'(out_instr_o), 64'(wbm_dat_i));
        end

        if (rd) begin
            q.delete();
            exp_fa = ra & 32'hFFFF_FFFC;
            halted = 1'b0;
            stale  = wbm_cyc_o && !term;
        end else begin
            if ((q.size() != 0) && rdy) void'(q.pop_front());
            if (term && !stale) begin
                if (!(byp && rdy)) begin
                    e.pc    = slv_addr;
                    e.instr = wbm_err_i ? 32'h0000_0013 : wbm_dat_i;
                    e.err   = wbm_err_i;
                    q.push_back(e);
                end
                if (wbm_err_i) halted = 1'b1;
                else           exp_fa = exp_fa + 32'd4;
            end
            if (term) stale = 1'b0;
        end
    endtask

    // Asserts reset between edges, checks the asynchronous response, then releases on a falling edge.
    task automatic apply_reset();
        #2 rst_ni = 1'b0;
        #1;
        check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_level", 64'(level_o), 64'd0);
        check("rst_instr", 64'(out_instr_o), 64'd0);
        check("rst_pc", 64'(out_pc_o), 64'd0);
        check("rst_err", 64'(out_err_o), 64'd0);
        out_ready_i = 1'b0;
        redirect_i  = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        wbm_dat_i   = '0;
        q.delete();
        exp_fa   = RESET_ADDR;
        halted   = 1'b0;
        stale    = 1'b0;
        slv_busy = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        found;
        logic [31:0] old_addr;
        int          n0;
        logic        rdy;
        logic        rd;
        logic [31:0] ra;

        // Reset release and zero-wait streaming.
        apply_reset();
        fixed_wait = 0;
        step(1'b1, 1'b0, '0);
        check("t1_cyc0", 64'(wbm_cyc_o), 64'd1);
        check("t1_addr0", 64'(wbm_addr_o), 64'h8000_0000);
`ifdef IF_PREFETCH_BYPASS_EN
        check("t1_bypass_valid", 64'(out_valid_o), 64'd1);
        check("t1_bypass_level", 64'(level_o), 64'd0);
`endif
        step(1'b1, 1'b0, '0);
        check("t1_addr1", 64'(wbm_addr_o), 64'h8000_0004);
`ifndef IF_PREFETCH_BYPASS_EN
        check("t1_pc0", 64'(out_pc_o), 64'h8000_0000);
`endif
        step(1'b1, 1'b0, '0);
        check("t1_addr2", 64'(wbm_addr_o), 64'h8000_0008);
`ifndef IF_PREFETCH_BYPASS_EN
        check("t1_pc1", 64'(out_pc_o), 64'h8000_0004);
`endif
        repeat (8) begin
            step(1'b1, 1'b0, '0);
            check("t1_level_le1", 64'(level_o <= 1), 64'd1);
        end

        // Consumer stalled: FIFO fills, bus goes idle, then drains in order.
        apply_reset();
        n0 = n_acks;
        repeat (12) step(1'b0, 1'b0, '0);
        check("t3_acks", 64'(n_acks - n0), 64'd4);
        check("t3_cyc_idle", 64'(wbm_cyc_o), 64'd0);
        check("t3_level_full", 64'(level_o), 64'd4);
        step(1'b1, 1'b0, '0);
        check("t3_head0", 64'(out_pc_o), 64'h8000_0000);
        step(1'b1, 1'b0, '0);
        check("t3_resume_cyc", 64'(wbm_cyc_o), 64'd1);
        check("t3_resume_addr", 64'(wbm_addr_o), 64'h8000_0010);
        repeat (6) step(1'b1, 1'b0, '0);

        // Redirect while a 3-wait-state cycle is open.
        fixed_wait = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            if (wbm_cyc_o && slv_busy) found = 1'b1;
        end
        check("t4_open_cycle", 64'(found), 64'd1);
        old_addr = slv_addr;
        step(1'b1, 1'b1, 32'h0000_1002);
        step(1'b1, 1'b0, '0);
        check("t4_drain_cyc", 64'(wbm_cyc_o), 64'd1);
        check("t4_drain_addr", 64'(wbm_addr_o), 64'(old_addr));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            if (out_valid_o) begin
                found = 1'b1;
                check("t4_first_pc", 64'(out_pc_o), 64'h0000_1000);
            end
        end
        check("t4_valid_seen", 64'(found), 64'd1);

        // Bus error halts fetching until a redirect.
        fixed_wait = 0;
        err_en     = 1'b1;
        err_addr   = 32'h8000_0008;
        step(1'b1, 1'b1, 32'h8000_0000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            if (out_valid_o && out_err_o) begin
                found = 1'b1;
                check("t5_err_pc", 64'(out_pc_o), 64'h8000_0008);
                check("t5_err_instr", 64'(out_instr_o), 64'h0000_0013);
            end
        end
        check("t5_err_seen", 64'(found), 64'd1);
        repeat (5) step(1'b1, 1'b0, '0);
        check("t5_halted", 64'(wbm_cyc_o), 64'd0);
        step(1'b1, 1'b1, 32'h8000_0100);
        step(1'b1, 1'b0, '0);
        check("t5_resume_cyc", 64'(wbm_cyc_o), 64'd1);
        check("t5_resume_addr", 64'(wbm_addr_o), 64'h8000_0100);
`ifndef IF_PREFETCH_BYPASS_EN
        check("t5_flush_valid", 64'(out_valid_o), 64'd0);
`endif
        err_en = 1'b0;

        // Redirect coinciding with an ack and a pop.
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h8000_0200);
        check("t6_coincide", 64'(wbm_ack_i && out_valid_o), 64'd1);
        step(1'b1, 1'b0, '0);
        check("t6_level0", 64'(level_o), 64'd0);
        check("t6_new_addr", 64'(wbm_addr_o), 64'h8000_0200);

        // Randomized traffic with wait states, errors, redirects and one mid-run reset.
        fixed_wait = -1;
        max_wait   = 3;
        rand_err   = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) apply_reset();
            if (((i / 200) % 3) == 2) rdy = ($urandom_range(0, 3) == 0);
            else                      rdy = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) ra = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           ra = $urandom;
            step(rdy, rd, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
